pool_window: RTL and testbench
==============================

POOL_WINDOW -- requirements
Module: pool_window

Interface
REQ-001 The module SHALL have parameter STRIDE, default 5, giving the samples advanced between consecutive windows (legal range 1..5).
REQ-002 The module SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit, asynchronous active-low reset.
REQ-004 The module SHALL have port in_valid, input, 1 bit, upstream conv sample valid.
REQ-005 The module SHALL have port in_data, input, 8 bits, unsigned feature sample.
REQ-006 The module SHALL have port in_last, input, 1 bit, marks the final sample of a channel.
REQ-007 The module SHALL have port in_ready, output, 1 bit, sample accepted when in_valid and in_ready are both high.
REQ-008 The module SHALL have ports win0..win4, output, 8 bits each, window samples with win0 oldest and win4 newest, wired to the max-pool inputs in1..in5.
REQ-009 The module SHALL have port win_valid, output, 1 bit, window valid, wired to the max-pool en.
REQ-010 The module SHALL have port win_ready, input, 1 bit, downstream takes the window when win_valid and win_ready are both high.
REQ-011 The module SHALL have port win_last, output, 1 bit, qualifies the final window of a channel.
REQ-012 The module SHALL have port ch_done, output, 1 bit, one-cycle pulse when a channel closes.

Function
REQ-013 The module SHALL hold a 5-entry shift register sr[0..4], fill count fc (0..5), stride count sc (0..STRIDE), and a first-window-emitted flag fw.
REQ-014 in_ready SHALL equal (not win_valid) or win_ready, so no pending window is ever overwritten.
REQ-015 On accept the module SHALL shift sr toward sr[0], write in_data to sr[4], and set fc' = min(fc+1,5) and sc' = sc+1.
REQ-016 An emit SHALL occur on an accept when fc' = 5 and either fw = 0 or sc' = STRIDE.
REQ-017 On an emit the module SHALL load win0..win4 from the post-shift sr[0..4], set win_valid the following cycle, clear sc, and set fw.
REQ-018 Latency from accepting the completing sample to win_valid high SHALL be exactly 1 cycle.
REQ-019 win0..win4, win_valid and win_last SHALL hold stable until a window handshake completes, then win_valid and win_last clear unless a new emit loads the registers in the same cycle.
REQ-020 If an emit occurs on the accept carrying in_last, win_last SHALL be set with that window.
REQ-021 Accepting a sample with in_last SHALL clear fc, sc and fw after any emit or pad, so the next channel starts empty with no sample carry-over.
REQ-022 ch_done SHALL pulse high for exactly one cycle, the cycle after accepting in_last, in every case.
REQ-023 No accept SHALL occur while in_ready is low; in_data and in_last are ignored then.
REQ-024 The module SHALL compare and store data unsigned only, with no arithmetic on samples.

Reset
REQ-025 While rst is low, the module SHALL asynchronously drive win_valid, win_last, ch_done, fc, sc, fw, sr[0..4] and win0..win4 to 0, and in_ready to 1.
REQ-026 Reset asserted mid-window or with a window pending SHALL discard all state; the first accept after release starts a new channel.

Configuration
REQ-027 With macro POOL_PAD_EN defined, an accept carrying in_last with no emit and fc' > 0 SHALL emit a padded window with win_last = 1.
REQ-028 The padded window SHALL be sr after further shifting in z zero samples, with z = 5 - fc' when fw = 0, else z = STRIDE - sc'.
REQ-029 Without POOL_PAD_EN, partial remainders SHALL be dropped, no window is emitted, and only ch_done marks channel end.

Verification
REQ-030 STRIDE=5; stream 1..10, last on 10, win_ready=1 -> windows (1,2,3,4,5) then (6,7,8,9,10) with win_last; ch_done once.
REQ-031 STRIDE=2; stream 1..7, last on 7 -> windows (1..5), (3..7) with win_last on the second window.
REQ-032 STRIDE=5; stream 1..7, last on 7 -> with POOL_PAD_EN: (1..5), then (3,4,5,6,7)? no: (6,7,0,0,0) with win_last; without the macro: (1..5) only, plus the ch_done pulse.
REQ-033 Hold win_ready=0 for 4 cycles after the first window -> in_ready=0, window outputs stable, no sample lost; release -> stream resumes.
REQ-034 Assert rst after 3 accepted samples, release, then stream 20..24 -> a single window (20,21,22,23,24).

Source files
------------

// File: rtl/pool_window.sv
// Sliding 5-sample window in front of a max-pool stage; windows advance by STRIDE samples.
// Define POOL_PAD_EN to zero-pad and emit the trailing partial window of each channel.
module pool_window #(
    parameter int STRIDE = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    input  logic       in_last,
    output logic       in_ready,
    output logic [7:0] win0,
    output logic [7:0] win1,
    output logic [7:0] win2,
    output logic [7:0] win3,
    output logic [7:0] win4,
    output logic       win_valid,
    input  logic       win_ready,
    output logic       win_last,
    output logic       ch_done
);

    localparam logic [2:0] STRIDE_W = 3'(STRIDE);

    logic [7:0] sr   [5];
    logic [7:0] nsr  [5];
    logic [7:0] load [5];
    logic [2:0] fc;
    logic [2:0] sc;
    logic [2:0] fc_n;
    logic [2:0] sc_n;
    logic [2:0] z;
    logic       fw;
    logic       accept;
    logic       handshake;
    logic       emit;
    logic       pad;

    // A pending window blocks new samples only while downstream is not taking it.
    assign in_ready = !win_valid || win_ready;

    always_comb begin
        accept    = in_valid && in_ready;
        handshake = win_valid && win_ready;
        fc_n      = (fc == 3'd5) ? 3'd5 : fc + 3'd1;
        sc_n      = sc + 3'd1;
        for (int i = 0; i < 4; i++) begin
            nsr[i] = sr[i + 1];
        end
        nsr[4] = in_data;
        emit   = accept && (fc_n == 3'd5) && (!fw || (sc_n == STRIDE_W));
        pad    = 1'b0;
        z      = 3'd0;
`ifdef POOL_PAD_EN
        pad = accept && in_last && !emit;
        z   = fw ? (STRIDE_W - sc_n) : (3'd5 - fc_n);
`endif
        for (int i = 0; i < 5; i++) begin
            load[i] = nsr[i];
        end
        // Padding pushes z zero samples in behind the newest real sample.
        for (int s = 0; s < 4; s++) begin
            if (pad && (3'(s) < z)) begin
                for (int i = 0; i < 4; i++) begin
                    load[i] = load[i + 1];
                end
                load[4] = 8'd0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 5; i++) begin
                sr[i] <= 8'd0;
            end
            fc        <= 3'd0;
            sc        <= 3'd0;
            fw        <= 1'b0;
            win0      <= 8'd0;
            win1      <= 8'd0;
            win2      <= 8'd0;
            win3      <= 8'd0;
            win4      <= 8'd0;
            win_valid <= 1'b0;
            win_last  <= 1'b0;
            ch_done   <= 1'b0;
        end else begin
            ch_done <= accept && in_last;
            if (accept) begin
                for (int i = 0; i < 5; i++) begin
                    sr[i] <= nsr[i];
                end
                if (in_last) begin
                    fc <= 3'd0;
                    sc <= 3'd0;
                    fw <= 1'b0;
                end else if (emit) begin
                    fc <= fc_n;
                    sc <= 3'd0;
                    fw <= 1'b1;
                end else begin
                    fc <= fc_n;
                    sc <= sc_n;
                end
            end
            // A new window may be loaded in the same cycle the previous one is taken.
            if (emit || pad) begin
                win0      <= load[0];
                win1      <= load[1];
                win2      <= load[2];
                win3      <= load[3];
                win4      <= load[4];
                win_valid <= 1'b1;
                win_last  <= in_last;
            end else if (handshake) begin
                win_valid <= 1'b0;
                win_last  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pool_window.sv
// Bench for pool_window: STRIDE=5 and STRIDE=2 instances checked against a sample-list model.
// Expectations follow POOL_PAD_EN when the bench is built with it defined.
`timescale 1ns/1ps
module tb_pool_window;

`ifdef POOL_PAD_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       win_ready;
    logic       in_valid  [2];
    logic [7:0] in_data   [2];
    logic       in_last   [2];
    logic       in_ready  [2];
    logic [7:0] win       [2][5];
    logic       win_valid [2];
    logic       win_last  [2];
    logic       ch_done   [2];

    pool_window #(.STRIDE(5)) u_s5 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_data(in_data[0]),
        .in_last(in_last[0]), .in_ready(in_ready[0]),
        .win0(win[0][0]), .win1(win[0][1]), .win2(win[0][2]), .win3(win[0][3]), .win4(win[0][4]),
        .win_valid(win_valid[0]), .win_ready(win_ready), .win_last(win_last[0]), .ch_done(ch_done[0])
    );

    pool_window #(.STRIDE(2)) u_s2 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_data(in_data[1]),
        .in_last(in_last[1]), .in_ready(in_ready[1]),
        .win0(win[1][0]), .win1(win[1][1]), .win2(win[1][2]), .win3(win[1][3]), .win4(win[1][4]),
        .win_valid(win_valid[1]), .win_ready(win_ready), .win_last(win_last[1]), .ch_done(ch_done[1])
    );

    always #5 clk = ~clk;

    typedef struct {
        int          first;
        int          len;
        int          n5;
        logic [39:0] w5;
        logic        f5;
        int          n2;
        logic [39:0] w2;
        logic        f2;
    } vec_t;

    vec_t vecs [5];

    // Reference model: every sample of the current channel, by index.
    logic [7:0]  chan    [2][1024];
    int          n       [2];
    logic        m_valid [2];
    logic        m_last  [2];
    logic        m_done  [2];
    logic [39:0] m_win   [2];
    logic        acc     [2];
    logic        hs      [2];

    int          got_n  [2];
    int          done_n [2];
    logic [39:0] got_w  [2];
    logic        got_f  [2];

    int errors = 0;
    int checks = 0;
    int wr_mode = 0;
    int stall = 0;

    function automatic int stride_of(input int d);
        return (d == 0) ? 5 : 2;
    endfunction

    function automatic logic [39:0] dut_win(input int d);
        return {win[d][0], win[d][1], win[d][2], win[d][3], win[d][4]};
    endfunction

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        for (int d = 0; d < 2; d++) begin
            n[d]       = 0;
            m_valid[d] = 1'b0;
            m_last[d]  = 1'b0;
            m_done[d]  = 1'b0;
            m_win[d]   = '0;
            acc[d]     = 1'b0;
            hs[d]      = 1'b0;
        end
    endtask

    task automatic clearCounts();
        for (int d = 0; d < 2; d++) begin
            got_n[d]  = 0;
            done_n[d] = 0;
            got_w[d]  = '0;
            got_f[d]  = 1'b0;
        end
    endtask

    // Windows start at sample 5 of a channel, then every STRIDE samples after it.
    task automatic modelUpdate(input int d);
        int m;
        int s;
        int keep;
        if (!rst) begin
            n[d]       = 0;
            m_valid[d] = 1'b0;
            m_last[d]  = 1'b0;
            m_done[d]  = 1'b0;
            return;
        end
        s = stride_of(d);
        m_done[d] = 1'b0;
        if (hs[d]) begin
            m_valid[d] = 1'b0;
            m_last[d]  = 1'b0;
        end
        if (acc[d]) begin
            chan[d][n[d]] = in_data[d];
            m = n[d] + 1;
            n[d] = m;
            if (m >= 5 && (m == 5 || (m - 5) % s == 0)) begin
                for (int i = 0; i < 5; i++) m_win[d][39 - 8*i -: 8] = chan[d][m - 5 + i];
                m_valid[d] = 1'b1;
                m_last[d]  = in_last[d];
            end else if (PAD_EN && in_last[d]) begin
                keep = (m < 5) ? m : 5 - s + (m - 5) % s;
                for (int i = 0; i < 5; i++)
                    m_win[d][39 - 8*i -: 8] = (i < keep) ? chan[d][m - keep + i] : 8'h00;
                m_valid[d] = 1'b1;
                m_last[d]  = 1'b1;
            end
            if (in_last[d]) begin
                n[d]      = 0;
                m_done[d] = 1'b1;
            end
        end
    endtask

    task automatic checkOutput(input int d);
        string p;
        p = (d == 0) ? "s5" : "s2";
        check({p, " in_ready"}, 40'(in_ready[d]), 40'(!m_valid[d] || win_ready));
        check({p, " win_valid"}, 40'(win_valid[d]), 40'(m_valid[d]));
        check({p, " win_last"}, 40'(win_last[d]), 40'(m_last[d]));
        check({p, " ch_done"}, 40'(ch_done[d]), 40'(m_done[d]));
        if (m_valid[d]) check({p, " window"}, dut_win(d), m_win[d]);
    endtask

    // One clock: choose win_ready, predict, clock, then compare at the falling edge.
    task automatic tick();
        if (stall > 0) begin
            win_ready = 1'b0;
            stall--;
        end else if (wr_mode == 1) begin
            win_ready = 1'($urandom_range(0, 1));
        end else begin
            win_ready = 1'b1;
        end
        for (int d = 0; d < 2; d++) begin
            acc[d] = rst && in_valid[d] && (!m_valid[d] || win_ready);
            hs[d]  = rst && m_valid[d] && win_ready;
            if (win_valid[d] && win_ready) begin
                got_n[d]++;
                got_w[d] = dut_win(d);
                got_f[d] = win_last[d];
            end
        end
        @(posedge clk);
        for (int d = 0; d < 2; d++) modelUpdate(d);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checkOutput(d);
            if (ch_done[d]) done_n[d]++;
        end
    endtask

    task automatic applyStimulus(input logic [7:0] data, input logic last);
        int guard;
        guard = 0;
        for (int d = 0; d < 2; d++) begin
            in_valid[d] = 1'b1;
            in_data[d]  = data;
            in_last[d]  = last;
        end
        while (in_valid[0] || in_valid[1]) begin
            tick();
            for (int d = 0; d < 2; d++) if (acc[d]) in_valid[d] = 1'b0;
            guard++;
            if (guard > 200) begin
                checks++;
                errors++;
                $display("[TB] FAIL accept timeout: sample %h not taken, want taken within 200 cycles", data);
                in_valid[0] = 1'b0;
                in_valid[1] = 1'b0;
            end
        end
    endtask

    task automatic checkResetState(input string tag);
        for (int d = 0; d < 2; d++) begin
            check({tag, " in_ready"}, 40'(in_ready[d]), 40'd1);
            check({tag, " win_valid"}, 40'(win_valid[d]), 40'd0);
            check({tag, " win_last"}, 40'(win_last[d]), 40'd0);
            check({tag, " ch_done"}, 40'(ch_done[d]), 40'd0);
            check({tag, " window"}, dut_win(d), 40'd0);
        end
    endtask

    initial begin
`ifdef POOL_PAD_EN
        vecs[0] = '{1, 10, 2, 40'h060708090a, 1'b1, 4, 40'h0708090a00, 1'b1};
        vecs[1] = '{1,  7, 2, 40'h0607000000, 1'b1, 2, 40'h0304050607, 1'b1};
        vecs[2] = '{20, 5, 1, 40'h1415161718, 1'b1, 1, 40'h1415161718, 1'b1};
        vecs[3] = '{1,  3, 1, 40'h0102030000, 1'b1, 1, 40'h0102030000, 1'b1};
        vecs[4] = '{1,  8, 2, 40'h0607080000, 1'b1, 3, 40'h0506070800, 1'b1};
`else
        vecs[0] = '{1, 10, 2, 40'h060708090a, 1'b1, 3, 40'h0506070809, 1'b0};
        vecs[1] = '{1,  7, 1, 40'h0102030405, 1'b0, 2, 40'h0304050607, 1'b1};
        vecs[2] = '{20, 5, 1, 40'h1415161718, 1'b1, 1, 40'h1415161718, 1'b1};
        vecs[3] = '{1,  3, 0, 40'h0,          1'b0, 0, 40'h0,          1'b0};
        vecs[4] = '{1,  8, 1, 40'h0102030405, 1'b0, 2, 40'h0304050607, 1'b0};
`endif
        rst = 1'b0;
        win_ready = 1'b1;
        for (int d = 0; d < 2; d++) begin
            in_valid[d] = 1'b0;
            in_data[d]  = 8'h00;
            in_last[d]  = 1'b0;
        end
        modelReset();
        clearCounts();
        #1;
        checkResetState("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Directed channels with downstream always ready.
        for (int v = 0; v < 5; v++) begin
            clearCounts();
            for (int k = 0; k < vecs[v].len; k++)
                applyStimulus(8'(vecs[v].first + k), k == vecs[v].len - 1);
            repeat (3) tick();
            check($sformatf("vec%0d s5 windows", v), 40'(got_n[0]), 40'(vecs[v].n5));
            check($sformatf("vec%0d s2 windows", v), 40'(got_n[1]), 40'(vecs[v].n2));
            if (vecs[v].n5 > 0) begin
                check($sformatf("vec%0d s5 final window", v), got_w[0], vecs[v].w5);
                check($sformatf("vec%0d s5 final last", v), 40'(got_f[0]), 40'(vecs[v].f5));
            end
            if (vecs[v].n2 > 0) begin
                check($sformatf("vec%0d s2 final window", v), got_w[1], vecs[v].w2);
                check($sformatf("vec%0d s2 final last", v), 40'(got_f[1]), 40'(vecs[v].f2));
            end
            check($sformatf("vec%0d s5 ch_done pulses", v), 40'(done_n[0]), 40'd1);
            check($sformatf("vec%0d s2 ch_done pulses", v), 40'(done_n[1]), 40'd1);
        end

        // Backpressure: downstream stalls 4 cycles with the first window pending.
        clearCounts();
        for (int k = 1; k <= 5; k++) applyStimulus(8'(k), 1'b0);
        stall = 4;
        for (int d = 0; d < 2; d++) begin
            in_valid[d] = 1'b1;
            in_data[d]  = 8'h06;
            in_last[d]  = 1'b0;
        end
        for (int c = 0; c < 4; c++) begin
            tick();
            check("stall s5 in_ready", 40'(in_ready[0]), 40'd0);
            check("stall s5 window hold", dut_win(0), 40'h0102030405);
            check("stall s2 window hold", dut_win(1), 40'h0102030405);
        end
        for (int k = 6; k <= 10; k++) applyStimulus(8'(k), k == 10);
        repeat (3) tick();
        check("stall s5 windows", 40'(got_n[0]), 40'd2);
        check("stall s5 final window", got_w[0], 40'h060708090a);
        check("stall s5 final last", 40'(got_f[0]), 40'd1);

        // Reset in the middle of a channel, then a fresh channel 20..24.
        for (int k = 1; k <= 3; k++) applyStimulus(8'(k), 1'b0);
        #2;
        rst = 1'b0;
        #1;
        checkResetState("midreset");
        tick();
        tick();
        rst = 1'b1;
        clearCounts();
        for (int k = 20; k <= 24; k++) applyStimulus(8'(k), k == 24);
        repeat (3) tick();
        check("post-reset s5 windows", 40'(got_n[0]), 40'd1);
        check("post-reset s5 window", got_w[0], 40'h1415161718);
        check("post-reset s2 windows", 40'(got_n[1]), 40'd1);
        check("post-reset s2 window", got_w[1], 40'h1415161718);

        // Random channels, random data, random downstream readiness and input gaps.
        wr_mode = 1;
        for (int c = 0; c < 12; c++) begin
            int len;
            len = $urandom_range(1, 14);
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 3) == 0) tick();
                applyStimulus(8'($urandom), k == len - 1);
            end
        end
        wr_mode = 0;
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
